goldschmidt_div: RTL and testbench

GOLDSCHMIDT_DIV -- requirements
Module: goldschmidt_div

---
 rtl/goldschmidt_div.sv | 150 +++++++++++++++
 tb/tb_goldschmidt_div.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/goldschmidt_div.sv
// Iterative Goldschmidt divider for normalised Q1.23 operands, producing a Q1.24 quotient.
// One time-shared 26x26 multiplier; an external reciprocal table supplies the seed factor.
module goldschmidt_div #(
    parameter int ITERS = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] dividend,
    input  logic [23:0] divisor,
    output logic [3:0]  lut_index,
    input  logic [23:0] lut_div,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [24:0] quotient,
    output logic        err
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] SCALE_N = 3'd1;
    localparam logic [2:0] SCALE_D = 3'd2;
    localparam logic [2:0] ITER_N  = 3'd3;
    localparam logic [2:0] ITER_D  = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    localparam logic [25:0] TWO     = 26'h2000000;  // 2.0 in Q2.24
    localparam logic [24:0] Q_SAT   = 25'h1FFFFFF;
    localparam logic [2:0]  ITERS_L = 3'(ITERS);

    logic [2:0]  state;
    logic [23:0] dividend_q;
    logic [23:0] divisor_q;
    logic [25:0] n_q;
    logic [25:0] d_q;
    logic [25:0] f_q;
    logic [2:0]  cnt;
    logic        err_q;
    logic [24:0] quot_q;

    logic [25:0] mul_a;
    logic [25:0] mul_b;
    logic [51:0] product;
    logic [25:0] prod_t;
    logic [2:0]  cnt_nx;
    logic [24:0] n_sat;

    // Operand select for the single shared multiplier; all operands are Q2.24.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        mul_a = '0;
        mul_b = '0;
        case (state)
            SCALE_N: begin
                mul_a = {1'b0, dividend_q, 1'b0};
                mul_b = {2'b00, lut_div};
            end
            SCALE_D: begin
                mul_a = {1'b0, divisor_q, 1'b0};
                mul_b = {2'b00, lut_div};
            end
            ITER_N: begin
                mul_a = n_q;
                mul_b = f_q;
            end
            ITER_D: begin
                mul_a = d_q;
                mul_b = f_q;
            end
            default: ;
        endcase
    end

    // Q4.48 product truncated back to Q2.24.
    assign product = {26'd0, mul_a} * {26'd0, mul_b};
    assign prod_t  = 26'(product >> 24);
    assign cnt_nx  = cnt + 3'd1;
    assign n_sat   = n_q[25] ? Q_SAT : n_q[24:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dividend_q <= '0;
            divisor_q  <= '0;
            n_q        <= '0;
            d_q        <= '0;
            f_q        <= '0;
            cnt        <= '0;
            err_q      <= 1'b0;
            quot_q     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dividend_q <= dividend;
                        divisor_q  <= divisor;
                        cnt        <= '0;
                        err_q      <= 1'b0;
                        state      <= SCALE_N;
                    end
                end
                SCALE_N: begin
                    if (!divisor_q[23]) begin
                        // Unnormalised divisor: report a saturated quotient without iterating.
                        err_q  <= 1'b1;
                        quot_q <= Q_SAT;
                        state  <= DONE;
                    end else begin
                        n_q   <= prod_t;
                        state <= SCALE_D;
                    end
                end
                SCALE_D: begin
                    d_q   <= prod_t;
                    f_q   <= TWO - prod_t;
                    state <= ITER_N;
                end
                ITER_N: begin
                    n_q   <= prod_t;
                    state <= ITER_D;
                end
                ITER_D: begin
                    d_q <= prod_t;
                    f_q <= TWO - prod_t;
                    cnt <= cnt_nx;
                    if (cnt_nx < ITERS_L) begin
                        state <= ITER_N;
                    end else begin
                        quot_q <= n_sat;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign quotient  = quot_q;
    assign err       = err_q;
    assign lut_index = divisor_q[22:19];

endmodule

// File: tb/tb_goldschmidt_div.sv
// Bench for goldschmidt_div: directed vector table, hand-written corner sequences and
// a random run, all scored against an exact-division scoreboard with a 4 LSB window.
module tb_goldschmidt_div;

    localparam int ITERS = 3;
    localparam int LAT   = 2 + 2 * ITERS;
    localparam int NV    = 9;
    localparam int NRAND = 3000;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] dividend;
    logic [23:0] divisor;
    logic [3:0]  lut_index;
    logic [23:0] lut_div;
    logic        out_valid;
    logic        out_ready;
    logic [24:0] quotient;
    logic        err;

    typedef struct {
        logic [23:0] dvd;
        logic [23:0] dvs;
        logic [24:0] exp_q;
        logic        exp_err;
        int          tol;
        int          hold;
        bit          chain;
    } vec_t;

    typedef struct {
        logic [24:0] q;
        logic        e;
        int          tol;
    } exp_t;

    vec_t        vecs [NV];
    exp_t        sb [$];
    logic [23:0] seed_rom [16];
    int          n_vec;
    int          n_err;

    goldschmidt_div #(.ITERS(ITERS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .lut_index (lut_index),
        .lut_div   (lut_div),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .err       (err)
    );

    // Reciprocal table: 1/(interval midpoint) for divisor in [1+i/16, 1+(i+1)/16).
    assign lut_div = seed_rom[lut_index];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input bit ok, input longint act, input longint exp);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [24:0] ref_quot(input logic [23:0] dvd, input logic [23:0] dvs);
        logic [47:0] num;
        logic [47:0] den;
        num = {dvd, 24'd0};
        den = {24'd0, dvs};
        return 25'(num / den);
    endfunction

    task automatic take_output();
        exp_t e;
        int   diff;
        if (sb.size() == 0) begin
            check("unexpected_output", 1'b0, 1, 0);
        end else begin
            e    = sb.pop_front();
            diff = int'(quotient) - int'(e.q);
            if (diff < 0) diff = -diff;
            check("quotient", diff <= e.tol, quotient, e.q);
            check("err", err == e.e, err, e.e);
        end
    endtask

    task automatic do_op(input logic [23:0] dvd, input logic [23:0] dvs,
                         input logic [24:0] exp_q, input logic exp_err, input int tol,
                         input int hold, input bit chain,
                         input logic [23:0] ndvd, input logic [23:0] ndvs);
        int          cyc;
        int          exp_lat;
        logic [24:0] q0;
        logic        e0;
        exp_lat  = dvs[23] ? LAT : 1;
        in_valid = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            step();
            cyc++;
        end
        check("accept_ready", in_ready == 1'b1, in_ready, 1);
        sb.push_back('{q: exp_q, e: exp_err, tol: tol});
        step();
        in_valid = 1'b0;
        dividend = 24'($urandom);
        divisor  = 24'($urandom);
        check("lut_index", lut_index == dvs[22:19], lut_index, dvs[22:19]);
        check("busy_ready", in_ready == 1'b0, in_ready, 0);
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            step();
            cyc++;
        end
        check("latency", cyc == exp_lat, cyc, exp_lat);
        if (out_valid) take_output();
        q0 = quotient;
        e0 = err;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom);
            dividend = 24'($urandom);
            divisor  = 24'($urandom);
            step();
            check("stall_valid", out_valid == 1'b1, out_valid, 1);
            check("stall_ready", in_ready == 1'b0, in_ready, 0);
            check("stall_quotient", quotient == q0, quotient, q0);
            check("stall_err", err == e0, err, e0);
        end
        in_valid  = chain;
        dividend  = chain ? ndvd : 24'($urandom);
        divisor   = chain ? ndvs : 24'($urandom);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("post_valid", out_valid == 1'b0, out_valid, 0);
        check("post_ready", in_ready == 1'b1, in_ready, 1);
    endtask

    initial begin
        int          ni;
        bit          seen;
        logic [23:0] rd;
        logic [23:0] rs;

        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 16; i++) seed_rom[i] = 24'((64'd1 << 29) / longint'(33 + 2 * i));

        //             dividend    divisor     quotient      err   tol hold chain
        vecs[0] = '{24'h800000, 24'h800000, 25'h1000000, 1'b0, 4, 0, 1'b0};
        vecs[1] = '{24'hC00000, 24'h800000, 25'h1800000, 1'b0, 4, 10, 1'b0};
        vecs[2] = '{24'h800000, 24'hFFFFFF, 25'h0800000, 1'b0, 4, 1, 1'b1};
        vecs[3] = '{24'h800000, 24'h400000, 25'h1FFFFFF, 1'b1, 0, 2, 1'b0};
        vecs[4] = '{24'h400000, 24'h800000, 25'h0800000, 1'b0, 4, 0, 1'b0};
        vecs[5] = '{24'hFFFFFF, 24'h800000, 25'h1FFFFFE, 1'b0, 4, 0, 1'b0};
        vecs[6] = '{24'hFFFFFF, 24'hFFFFFF, 25'h1000000, 1'b0, 4, 0, 1'b0};
        vecs[7] = '{24'h800000, 24'hC00000, 25'h0AAAAAA, 1'b0, 4, 0, 1'b0};
        vecs[8] = '{24'h000000, 24'hC00000, 25'h0000000, 1'b0, 4, 0, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) step();
        check("rst_out_valid", out_valid == 1'b0, out_valid, 0);
        check("rst_in_ready", in_ready == 1'b1, in_ready, 1);
        check("rst_quotient", quotient == 25'd0, quotient, 0);
        check("rst_err", err == 1'b0, err, 0);
        check("rst_lut_index", lut_index == 4'd0, lut_index, 0);
        rst_n = 1'b1;

        // Directed table; row 2 presents the next operands during its output handshake.
        for (int i = 0; i < NV; i++) begin
            ni = (i + 1 < NV) ? i + 1 : i;
            do_op(vecs[i].dvd, vecs[i].dvs, vecs[i].exp_q, vecs[i].exp_err, vecs[i].tol,
                  vecs[i].hold, vecs[i].chain, vecs[ni].dvd, vecs[ni].dvs);
        end

        // Reset while in ITER_D abandons the operation.
        in_valid = 1'b1;
        dividend = 24'hC00000;
        divisor  = 24'hA00000;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("midrst_out_valid", out_valid == 1'b0, out_valid, 0);
        check("midrst_in_ready", in_ready == 1'b1, in_ready, 1);
        check("midrst_quotient", quotient == 25'd0, quotient, 0);
        check("midrst_lut_index", lut_index == 4'd0, lut_index, 0);
        step();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_output", seen == 1'b0, seen, 0);
        do_op(24'h800000, 24'h800000, 25'h1000000, 1'b0, 4, 0, 1'b0, 24'd0, 24'd0);

        // Random normalised operands with random back-pressure.
        for (int k = 0; k < NRAND; k++) begin
            rd = {1'b1, 23'($urandom)};
            rs = {1'b1, 23'($urandom)};
            do_op(rd, rs, ref_quot(rd, rs), 1'b0, 4, int'($urandom_range(0, 2)), 1'b0, 24'd0, 24'd0);
        end

        check("scoreboard_empty", sb.size() == 0, sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
